// File: rtl/down_counter.sv
// Loadable, handshaked down-counter: loads A on Start, decrements once per
// enabled cycle until zero, then holds Done until Ack or Abort.
module down_counter #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] A,
    input  logic                 En,
    input  logic                 Abort,
    input  logic                 Ack,
    output logic [DATAWIDTH-1:0] D,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_next_s;
    logic [DATAWIDTH-1:0] d_r;
    logic [DATAWIDTH-1:0] d_next_s;

    // Next-state and next-count decode
    always_comb begin
        state_next_s = state_r;
        d_next_s     = d_r;
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    d_next_s = A;
                    if (A != {DATAWIDTH{1'b0}}) begin
                        state_next_s = S_RUN;
                    end else begin
                        state_next_s = S_DONE;
                    end
                end else begin
                    d_next_s = d_r;
                end
            end
            S_RUN: begin
                // Abort keeps the partial count so software can inspect it
                if (Abort) begin
                    state_next_s = S_IDLE;
                end else if (En) begin
                    d_next_s = d_r - ONE;
                    if (d_r == ONE) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_RUN;
                    end
                end else begin
                    d_next_s = d_r;
                end
            end
            S_DONE: begin
                d_next_s = {DATAWIDTH{1'b0}};
                if (Ack || Abort) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                d_next_s     = {DATAWIDTH{1'b0}};
            end
        endcase
    end

    // State and count registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= S_IDLE;
            d_r     <= {DATAWIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            d_r     <= d_next_s;
        end
    end

    assign D    = d_r;
    assign Busy = (state_r == S_RUN);
    assign Done = (state_r == S_DONE);
    assign Zero = (d_r == {DATAWIDTH{1'b0}});

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter (DATAWIDTH=8): a phase/remaining-count
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_down_counter;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Start = 1'b0;
    logic [W-1:0] A = 8'd0;
    logic         En = 1'b0;
    logic         Abort = 1'b0;
    logic         Ack = 1'b0;
    logic [W-1:0] D;
    logic         Busy;
    logic         Done;
    logic         Zero;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_on  = 1'b0;

    // Model: phase 0=idle 1=counting 2=finished, plus the remaining count
    int m_phase = 0;
    int m_val   = 0;

    down_counter #(.DATAWIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .A(A), .En(En), .Abort(Abort),
        .Ack(Ack), .D(D), .Busy(Busy), .Done(Done), .Zero(Zero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_phase = 0;
            m_val   = 0;
        end else begin
            case (m_phase)
                0: if (Start) begin
                    m_val   = int'(A);
                    m_phase = (A == 8'd0) ? 2 : 1;
                end
                1: if (Abort) begin
                    m_phase = 0;
                end else if (En) begin
                    m_val = m_val - 1;
                    if (m_val == 0) m_phase = 2;
                end
                2: if (Ack || Abort) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (cmp_on) begin
            chk("model_D",    int'(D),    m_val);
            chk("model_Busy", int'(Busy), (m_phase == 1) ? 1 : 0);
            chk("model_Done", int'(Done), (m_phase == 2) ? 1 : 0);
            chk("model_Zero", int'(Zero), (m_val == 0) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int lat;

        // Reset state
        tick();
        tick();
        cmp_on = 1'b1;
        chk("rst_D", int'(D), 0);
        chk("rst_Busy", int'(Busy), 0);
        chk("rst_Done", int'(Done), 0);
        chk("rst_Zero", int'(Zero), 1);
        Rst = 1'b1;
        tick();

        // Basic count A=3
        Start = 1'b1; A = 8'd3; En = 1'b1;
        tick();
        Start = 1'b0;
        chk("basic_load_D", int'(D), 3);
        chk("basic_load_Busy", int'(Busy), 1);
        tick(); chk("basic_D2", int'(D), 2);
        tick(); chk("basic_D1", int'(D), 1);
        tick(); chk("basic_D0", int'(D), 0);
        chk("basic_Done", int'(Done), 1);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk("basic_ack_Done", int'(Done), 0);
        chk("basic_ack_Busy", int'(Busy), 0);

        // Stall: A=4, En low on two cycles -> Done 6 edges after load edge
        Start = 1'b1; A = 8'd4;
        tick();
        Start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            En = (i != 1 && i != 3);
            tick();
            if (i == 1) chk("stall_hold_D", int'(D), 4);
            if (Done) begin
                lat = i;
                break;
            end
        end
        chk("stall_latency", lat, 6);
        En = 1'b1; Ack = 1'b1;
        tick();
        Ack = 1'b0;

        // Zero load, then Abort out of DONE
        Start = 1'b1; A = 8'd0;
        tick();
        Start = 1'b0;
        chk("zero_Done", int'(Done), 1);
        chk("zero_Busy", int'(Busy), 0);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("done_abort_Done", int'(Done), 0);

        // Abort beats En at D=7
        Start = 1'b1; A = 8'd10; En = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_D", int'(D), 7);
        Abort = 1'b1;
        tick();
        Abort = 1'b0; En = 1'b0;
        chk("abort_D", int'(D), 7);
        chk("abort_Busy", int'(Busy), 0);
        chk("abort_Done", int'(Done), 0);
        tick();
        chk("abort_hold_D", int'(D), 7);

        // Start ignored in RUN; Ack+Start in DONE drops Start
        Start = 1'b1; A = 8'd5; En = 1'b1;
        tick();
        A = 8'd9;
        tick();
        Start = 1'b0;
        chk("ign_start_D", int'(D), 4);
        for (int i = 0; i < 10 && !Done; i++) tick();
        chk("ign_reach_Done", int'(Done), 1);
        Ack = 1'b1; Start = 1'b1; A = 8'd9;
        tick();
        Ack = 1'b0; Start = 1'b0;
        chk("ackstart_D", int'(D), 0);
        chk("ackstart_Done", int'(Done), 0);
        chk("ackstart_Busy", int'(Busy), 0);
        tick();
        chk("ackstart_idle_Busy", int'(Busy), 0);

        // Asynchronous reset mid-RUN at D=5
        Start = 1'b1; A = 8'd8; En = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        chk("rst_pre_D", int'(D), 5);
        En = 1'b0;
        #1 Rst = 1'b0;
        #1;
        chk("arst_D", int'(D), 0);
        chk("arst_Busy", int'(Busy), 0);
        chk("arst_Done", int'(Done), 0);
        chk("arst_Zero", int'(Zero), 1);
        tick();
        Rst = 1'b1;
        tick();

        // Width boundary: A=255 -> Done after 256 edges, no wrap
        Start = 1'b1; A = 8'd255; En = 1'b1;
        tick();
        Start = 1'b0;
        lat = 0;
        for (int i = 2; i <= 300; i++) begin
            tick();
            if (D == 8'd255) chk("wide_no_wrap", int'(D), 254);
            if (Done) begin
                lat = i;
                break;
            end
        end
        chk("wide_latency", lat, 256);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        tick();

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
